// File: rtl/particle_cell_writer.sv
// Appends streamed particle records into per-cell slots of a banked cell memory and,
// at step end, writes a null terminator into every non-full cell before clearing counters.
module particle_cell_writer #(
    parameter int unsigned NUM_CELLS  = 27,
    parameter int unsigned CELL_DEPTH = 64,
    parameter int unsigned ADDR_W     = 6,
    parameter int unsigned CELL_W     = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [32:0]       in_cidx,
    input  logic [96:0]       in_pos,
    input  logic              step_end,
    input  logic              clear_err,
    output logic              mem_we,
    output logic [CELL_W-1:0] mem_cell,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [96:0]       mem_wdata,
    output logic              step_done,
    input  logic [CELL_W-1:0] cnt_sel,
    output logic [ADDR_W:0]   cnt_out,
    output logic              overflow,
    output logic              bad_index
);

    localparam logic [ADDR_W:0]   FULL_CNT  = (ADDR_W + 1)'(CELL_DEPTH);
    localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W + 1)'(1);
    localparam logic [CELL_W-1:0] LAST_CELL = CELL_W'(NUM_CELLS - 1);
    localparam logic [CELL_W-1:0] CELL_ONE  = CELL_W'(1);

    typedef enum logic [1:0] {StAccept, StTerm, StDone} state_e;

    state_e              state_q, state_d;
    logic [CELL_W-1:0]   t_q, t_d;
    logic [ADDR_W:0]     cnt_q [NUM_CELLS];

    logic                mem_we_q, mem_we_d;
    logic [CELL_W-1:0]   mem_cell_q, mem_cell_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [96:0]         mem_wdata_q, mem_wdata_d;
    logic                overflow_q, overflow_d;
    logic                bad_index_q, bad_index_d;

    logic                accept;
    logic                idx_ok;
    logic [CELL_W-1:0]   in_cell;
    logic [ADDR_W:0]     in_cnt;
    logic [ADDR_W:0]     term_cnt;
    logic                cnt_inc;
    logic                cnt_clr;
    logic                set_ovf;
    logic                set_bad;
    logic                unused_cidx;

    assign unused_cidx = in_cidx[32];

    assign in_ready  = (state_q == StAccept);
    assign step_done = (state_q == StDone);
    assign mem_we    = mem_we_q;
    assign mem_cell  = mem_cell_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign overflow  = overflow_q;
    assign bad_index = bad_index_q;

    // Out-of-range indices are steered to cell 0 so the counter lookup stays in bounds.
    assign accept   = in_valid & in_ready;
    assign idx_ok   = (in_cidx[31:0] < NUM_CELLS);
    assign in_cell  = idx_ok ? in_cidx[CELL_W-1:0] : '0;
    assign in_cnt   = cnt_q[in_cell];
    assign term_cnt = cnt_q[t_q];

    always_comb begin
        cnt_out = '0;
        if (32'(cnt_sel) < NUM_CELLS) begin
            cnt_out = cnt_q[cnt_sel];
        end
    end

    always_comb begin
        set_bad = accept & in_pos[96] & ~idx_ok;
        set_ovf = accept & in_pos[96] & idx_ok & (in_cnt == FULL_CNT);
        cnt_inc = accept & in_pos[96] & idx_ok & (in_cnt != FULL_CNT);

        // A new error in the same cycle as clear_err keeps the flag set.
        overflow_d  = set_ovf | (overflow_q & ~clear_err);
        bad_index_d = set_bad | (bad_index_q & ~clear_err);
    end

    always_comb begin
        state_d     = state_q;
        t_d         = t_q;
        cnt_clr     = 1'b0;
        mem_we_d    = 1'b0;
        mem_cell_d  = mem_cell_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;

        unique case (state_q)
            StAccept: begin
                if (cnt_inc) begin
                    mem_we_d    = 1'b1;
                    mem_cell_d  = in_cell;
                    mem_addr_d  = in_cnt[ADDR_W-1:0];
                    mem_wdata_d = in_pos;
                end
                if (step_end) begin
                    state_d = StTerm;
                    t_d     = '0;
                end
            end
            StTerm: begin
                if (term_cnt != FULL_CNT) begin
                    mem_we_d    = 1'b1;
                    mem_cell_d  = t_q;
                    mem_addr_d  = term_cnt[ADDR_W-1:0];
                    mem_wdata_d = '0;
                end
                if (t_q == LAST_CELL) begin
                    state_d = StDone;
                end else begin
                    t_d = t_q + CELL_ONE;
                end
            end
            StDone: begin
                cnt_clr = 1'b1;
                state_d = StAccept;
            end
            default: begin
                state_d = StAccept;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StAccept;
            t_q         <= '0;
            mem_we_q    <= 1'b0;
            mem_cell_q  <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            overflow_q  <= 1'b0;
            bad_index_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            t_q         <= t_d;
            mem_we_q    <= mem_we_d;
            mem_cell_q  <= mem_cell_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            overflow_q  <= overflow_d;
            bad_index_q <= bad_index_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CELLS; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CELLS; i++) begin
                if (cnt_clr) begin
                    cnt_q[i] <= '0;
                end else if (cnt_inc && (in_cell == CELL_W'(i))) begin
                    cnt_q[i] <= cnt_q[i] + CNT_ONE;
                end
            end
        end
    end

endmodule

// File: doc/particle_cell_writer.md
Name: particle_cell_writer

Overview:
- Consumer side of the position-update / cell-index stage.
- Accepts streamed particle records, each an updated position plus a target cell index (0..26 in the 3x3x3 neighbourhood), and appends each record into that cell's slot of a banked cell memory.
- Maintains a per-cell write counter and handles overflow and illegal indices.
- On step end, writes a null terminator into every non-full cell, then clears the counters for the next timestep.

Parameters:
- NUM_CELLS, 27, number of destination cells.
- CELL_DEPTH, 64, particle slots per cell.
- ADDR_W, 6, slot address width; CELL_DEPTH must equal 2^ADDR_W.
- CELL_W, 5, cell select width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  record present on in_cidx/in_pos.
- in_ready  out  1  writer accepts a record this cycle.
- in_cidx  in  33  [31:0] unsigned cell index; [32] ignored.
- in_pos  in  97  3 x fp32 position (x [31:0], y [63:32], z [95:64]); [96] particle-present flag.
- step_end  in  1  single-cycle pulse: no more records this timestep.
- clear_err  in  1  clears the sticky error flags.
- mem_we  out  1  write strobe to the cell memory.
- mem_cell  out  CELL_W  target cell of the write.
- mem_addr  out  ADDR_W  slot within the cell.
- mem_wdata  out  97  record written.
- step_done  out  1  one-cycle pulse when termination is complete.
- cnt_sel  in  CELL_W  selects the counter shown on cnt_out.
- cnt_out  out  ADDR_W+1  occupancy of cell cnt_sel; combinational read; 0 if cnt_sel >= NUM_CELLS.
- overflow  out  1  sticky: a record targeted a full cell.
- bad_index  out  1  sticky: in_cidx[31:0] >= NUM_CELLS.

Behaviour:
- Reset (async, rst_n=0):
  - State goes to ACCEPT; all counters = 0.
  - mem_we = 0, mem_cell = 0, mem_addr = 0, mem_wdata = 0.
  - step_done = 0, overflow = 0, bad_index = 0.
  - in_ready = 1 once reset is released.
  - Reset mid-TERM abandons the termination with no further writes.
- States:
  - ACCEPT: in_ready = 1.
  - TERM: in_ready = 0; iterates t = 0..NUM_CELLS-1, one cell per cycle.
  - DONE: one cycle; in_ready = 0.
- Accept rule: a transfer occurs when in_valid & in_ready. For an accepted record with index c = in_cidx[31:0]:
  - in_pos[96] = 0: record consumed and discarded; no write, no counter change.
  - c >= NUM_CELLS: discarded; bad_index set.
  - cnt[c] == CELL_DEPTH: discarded; overflow set.
  - Otherwise, on the next cycle: mem_we = 1, mem_cell = c, mem_addr = cnt[c] (low ADDR_W bits), mem_wdata = in_pos. cnt[c] increments at the same edge the transfer is accepted.
- Write latency is exactly 1 cycle. mem_* are registered outputs; mem_we is high for exactly one cycle per write.
- Back-to-back throughput: 1 record per cycle, including repeated records to the same cell, which receive consecutive addresses.
- step_end in ACCEPT:
  - A record transferred in the same cycle is processed first.
  - The transition to TERM happens at that edge (cycle N).
  - step_end while in TERM or DONE is ignored.
- TERM, cycle N+1+t:
  - If cnt[t] < CELL_DEPTH, a write appears on the following cycle: mem_cell = t, mem_addr = cnt[t], mem_wdata = 97'b0 (flag bit 0 is the terminator).
  - Full cells receive no terminator.
- DONE, cycle N+28 (NUM_CELLS=27):
  - step_done = 1.
  - The final terminator write (cell 26) is visible in the same cycle.
  - All counters clear at the end of DONE.
  - ACCEPT resumes at N+29.
- Sticky flags: cleared only by reset or clear_err. If clear_err coincides with a new error, the set wins.
- Counter width is ADDR_W+1, so a full cell reads CELL_DEPTH.

Test Plan:
- Reset, then 3 valid records (flag=1) to cells 4, 4, 13 on consecutive cycles -> mem_we on 3 consecutive cycles starting 1 cycle after the first accept: (4,0), (4,1), (13,0); cnt_out(sel=4) = 2, cnt_out(sel=13) = 1.
- 65 valid records to cell 0 -> 64 writes with addresses 0..63; the 65th produces no write; overflow = 1; cnt_out(0) = 64; clear_err -> overflow = 0.
- Record with in_cidx = 27, then a record with in_pos[96] = 0 to cell 2 -> no writes; bad_index = 1; cnt_out(2) = 0.
- Cell 0 full (64 entries), cell 5 holding 3, then step_end -> exactly 26 terminator writes, cell 0 skipped; cell 5 write at addr 3 with data 0; step_done 28 cycles after step_end; all counters read 0 afterwards; in_ready high at +29.
- step_end coincident with an accepted record to cell 7 (empty) -> record written at (7,0), then terminator at (7,1); a second step_end during TERM is ignored (only one step_done).
- rst_n low at TERM t=10 -> all outputs go to reset values immediately; no writes after release until a new accepted record; counters = 0.
